pdm_cic_decimator: RTL and testbench

- Downstream consumer of the 1-bit PDM stream produced by pdm_modulator.
- Acts as a sinc^ORDER (CIC) decimation filter.
- Samples `sdi` on rising edges of the PDM bit clock `ock` and accumulates in ORDER integrators.
- Every DEC bits, runs ORDER pipelined comb stages and presents an unsigned left-justified 32-bit PCM sample on a valid/ready port.
- Output scale matches the modulator's `din` convention: full scale 0..2^32-1, mid-scale 2^31.

---
 rtl/pdm_cic_decimator_if.sv | 25 ++
 rtl/pdm_cic_decimator.sv | 163 ++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_cic_decimator_if.sv
// PCM sample port of the PDM CIC decimator: sample, valid/ready handshake
// and sticky overrun flag. master = decimator, slave = consumer.
`timescale 1ns/1ps
interface pdm_cic_decimator_if #(
    parameter int OW = 32
);
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          overrun;

    modport master (
        output dout,
        output dout_valid,
        output overrun,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  overrun,
        output dout_ready
    );
endinterface

// File: rtl/pdm_cic_decimator.sv
// sinc^ORDER CIC decimator for a 1-bit PDM stream sampled on ock rising edges.
// Ports: clk, rstn (async low), en, sdi, ock; m = PCM sample port (master).
`timescale 1ns/1ps
module pdm_cic_decimator #(
    parameter int ORDER = 3,
    parameter int DEC   = 64,
    parameter int OW    = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    sdi,
    input  logic                    ock,
    pdm_cic_decimator_if.master     m
);
    localparam int LD = $clog2(DEC);
    localparam int W  = ORDER * LD;
    localparam int IW = W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMB,
        S_OUT
    } state_t;

    logic          ock_s1_q;
    logic          ock_s2_q;
    logic          ock_s3_q;
    logic          sdi_s1_q;
    logic          sdi_s2_q;
    logic          strobe;

    logic [IW-1:0] integ_q [ORDER];
    logic [IW-1:0] integ_d [ORDER];
    logic [IW-1:0] comb_q  [ORDER];
    logic [IW-1:0] dly_q   [ORDER];
    logic [LD-1:0] cnt_q;
    state_t        state_q;
    logic [2:0]    stg_q;
    logic [2:0]    wu_q;
    logic [OW-1:0] dout_q;
    logic          valid_q;
    logic          ovr_q;

    logic [IW-1:0] y;
    logic [W-1:0]  y_sat;
    logic [OW-1:0] fmt;

    assign strobe = ock_s2_q & ~ock_s3_q;

    // Synchronisers are unaffected by en.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ock_s1_q <= 1'b0;
            ock_s2_q <= 1'b0;
            ock_s3_q <= 1'b0;
            sdi_s1_q <= 1'b0;
            sdi_s2_q <= 1'b0;
        end else begin
            ock_s1_q <= ock;
            ock_s2_q <= ock_s1_q;
            ock_s3_q <= ock_s2_q;
            sdi_s1_q <= sdi;
            sdi_s2_q <= sdi_s1_q;
        end
    end

    // Registered cascade: every stage adds the pre-update value of the one before.
    always_comb begin
        integ_d = integ_q;
        integ_d[0] = integ_q[0] + IW'(sdi_s2_q);
        for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    // Gain is exactly 2^W, so only the all-ones case reaches y[W].
    always_comb begin
        y     = comb_q[ORDER-1];
        y_sat = y[W] ? {W{1'b1}} : y[W-1:0];
        fmt   = OW'(y_sat) << (OW - W);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
            end
            cnt_q   <= '0;
            state_q <= S_IDLE;
            stg_q   <= '0;
            wu_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (!en) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
            end
            cnt_q   <= '0;
            state_q <= S_IDLE;
            stg_q   <= '0;
            wu_q    <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (strobe) begin
                integ_q <= integ_d;
                cnt_q   <= cnt_q + 1'b1;
            end
            if (valid_q && m.dout_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (strobe && cnt_q == LD'(DEC - 1)) begin
                        state_q <= S_COMB;
                        stg_q   <= '0;
                    end
                end
                S_COMB: begin
                    // Stage 0 snapshots the last integrator directly.
                    if (stg_q == 3'd0) begin
                        comb_q[0] <= integ_q[ORDER-1] - dly_q[0];
                        dly_q[0]  <= integ_q[ORDER-1];
                    end
                    for (int k = 1; k < ORDER; k++) begin
                        if (stg_q == 3'(k)) begin
                            comb_q[k] <= comb_q[k-1] - dly_q[k];
                            dly_q[k]  <= comb_q[k-1];
                        end
                    end
                    if (stg_q == 3'(ORDER - 1)) begin
                        state_q <= S_OUT;
                    end else begin
                        stg_q <= stg_q + 3'd1;
                    end
                end
                S_OUT: begin
                    state_q <= S_IDLE;
                    if (wu_q < 3'(ORDER + 1)) begin
                        wu_q <= wu_q + 3'd1;
                    end else begin
                        dout_q  <= fmt;
                        valid_q <= 1'b1;
                        if (valid_q && !m.dout_ready) begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m.dout       = dout_q;
    assign m.dout_valid = valid_q;
    assign m.overrun    = ovr_q;
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: PDM patterns against a boxcar^ORDER model.
// Covers reset, warm-up, latency, saturation, overrun, en and mid-comb reset.
`timescale 1ns/1ps
module tb_pdm_cic_decimator;
    localparam int ORDER = 3;
    localparam int DEC   = 64;
    localparam int OW    = 32;
    localparam int LD    = 6;
    localparam int W     = ORDER * LD;
    localparam int HLEN  = ORDER * (DEC - 1) + 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic en   = 1'b0;
    logic sdi  = 1'b0;
    logic ock  = 1'b0;
    bit   ock_run = 1'b0;
    int   mode = 0;
    int   dens = 50;

    bit     bits[$];
    longint h[HLEN];
    time    t_ock = 0;
    logic [63:0] last_dout = '0;

    int n_assert = 0;
    int n_fail   = 0;

    pdm_cic_decimator_if #(.OW(OW)) pcm();

    pdm_cic_decimator #(
        .ORDER(ORDER),
        .DEC  (DEC),
        .OW   (OW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .en  (en),
        .sdi (sdi),
        .ock (ock),
        .m   (pcm)
    );

    always #5 clk = ~clk;

    // ock: 120 ns period, edges never coincide with clk edges.
    initial begin
        #2;
        forever begin
            #60;
            ock = ock_run ? ~ock : 1'b0;
        end
    end

    always @(negedge ock) begin
        case (mode)
            0:       sdi = 1'b0;
            1:       sdi = 1'b1;
            2:       sdi = ~sdi;
            default: sdi = ($urandom_range(0, 99) < dens);
        endcase
    end

    always @(posedge ock) begin
        bits.push_back(sdi);
        t_ock = $time;
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output n (1-based) is the boxcar^ORDER sum ending at bit n*DEC-1,
    // shifted by the ORDER-1 strobes of the registered integrator cascade.
    function automatic logic [63:0] model(int n);
        longint acc;
        int     last;
        int     idx;
        acc  = 0;
        last = n * DEC - 1 - (ORDER - 1);
        for (int m = 0; m < HLEN; m++) begin
            idx = last - m;
            if (idx >= 0 && idx < bits.size()) begin
                if (bits[idx]) acc += h[m];
            end
        end
        if (acc > (longint'(1) << W) - 1) acc = (longint'(1) << W) - 1;
        return 64'(acc) << (OW - W);
    endfunction

    task automatic wait_valid(int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (pcm.dout_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic collect(int cnt, bit first, string tag);
        for (int k = 0; k < cnt; k++) begin
            bit  got;
            int  n;
            time dt;
            wait_valid(6000, got);
            chk({tag, "_tmo"}, 64'(got), 64'd1);
            if (!got) return;
            n  = bits.size() / DEC;
            dt = $time - t_ock;
            if (first && k == 0) chk({tag, "_warmup_n"}, 64'(n), 64'(ORDER + 2));
            chk({tag, "_align"}, 64'(bits.size() % DEC), 64'd0);
            chk({tag, "_lat"}, 64'(dt > 60 && dt <= 71), 64'd1);
            chk({tag, "_dout"}, 64'(pcm.dout), model(n));
            last_dout = 64'(pcm.dout);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        longint tmp[HLEN];
        int     len;
        int     target;
        int     n;
        bit     got;

        // Impulse response of ORDER cascaded DEC-long boxcars.
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        for (int s = 0; s < ORDER; s++) begin
            for (int i = 0; i < HLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < DEC; j++) tmp[i+j] += h[i];
            for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
            len += DEC - 1;
        end

        pcm.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 64'(pcm.dout), 64'd0);
        chk("rst_valid", 64'(pcm.dout_valid), 64'd0);
        chk("rst_ovr", 64'(pcm.overrun), 64'd0);

        // All ones: saturated full scale after the warm-up discards.
        rstn = 1'b1;
        en   = 1'b1;
        mode = 1;
        @(posedge clk);
        ock_run = 1'b1;
        collect(3, 1'b1, "ones");
        chk("ones_val", last_dout, 64'hFFFF_C000);

        mode = 2;
        collect(6, 1'b0, "alt");
        chk("alt_val", last_dout, 64'h8000_0000);

        mode = 0;
        collect(5, 1'b0, "zero");
        chk("zero_val", last_dout, 64'd0);
        chk("zero_ovr", 64'(pcm.overrun), 64'd0);

        mode = 3;
        dens = 30;
        collect(3, 1'b0, "rnd30");
        dens = 85;
        collect(3, 1'b0, "rnd85");

        // Consumer stalls for three output periods.
        dens = 60;
        pcm.dout_ready = 1'b0;
        target = (bits.size() / DEC + 3) * DEC + DEC / 2;
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (bits.size() >= target) begin
                got = 1'b1;
                break;
            end
        end
        chk("stall_tmo", 64'(got), 64'd1);
        n = bits.size() / DEC;
        chk("stall_ovr", 64'(pcm.overrun), 64'd1);
        chk("stall_valid", 64'(pcm.dout_valid), 64'd1);
        chk("stall_dout", 64'(pcm.dout), model(n));
        pcm.dout_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("xfer_valid", 64'(pcm.dout_valid), 64'd0);
        chk("xfer_ovr", 64'(pcm.overrun), 64'd1);
        collect(2, 1'b0, "post_stall");
        chk("ovr_sticky", 64'(pcm.overrun), 64'd1);

        // en low for 10 clk, timed so the re-enable sits between strobes.
        @(posedge ock);
        #50;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("en_valid", 64'(pcm.dout_valid), 64'd0);
            chk("en_ovr", 64'(pcm.overrun), 64'd0);
        end
        en = 1'b1;
        bits.delete();
        collect(2, 1'b1, "reen");

        // Reset in the middle of the comb pass.
        mode = 1;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (bits.size() % DEC == 1) begin
                got = 1'b1;
                break;
            end
        end
        chk("mid_tmo1", 64'(got), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (bits.size() % DEC == 0) begin
                got = 1'b1;
                break;
            end
        end
        chk("mid_tmo2", 64'(got), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_dout", 64'(pcm.dout), 64'd0);
        chk("mid_valid", 64'(pcm.dout_valid), 64'd0);
        chk("mid_ovr", 64'(pcm.overrun), 64'd0);
        ock_run = 1'b0;
        repeat (20) @(posedge clk);
        bits.delete();
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        ock_run = 1'b1;
        collect(2, 1'b1, "post_rst");
        chk("post_rst_val", last_dout, 64'hFFFF_C000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
